// File: rtl/spi_pkg.sv
// Shared types and command codes for the parametrised SPI slave.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData,
        StTxWait,
        StTxShift,
        StWaitEnd
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // True when the received command code matches the frame type chosen in CHK_CMD.
    function automatic logic cmd_legal(input spi_state_e st, input logic [1:0] cmd);
        logic ok;
        ok = 1'b0;
        case (st)
            StWrite:    ok = (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
            StReadAdd:  ok = (cmd == CMD_RD_ADDR);
            StReadData: ok = (cmd == CMD_RD_DATA);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Loadable shift register with serial in/out and a shift counter.
// last_o flags that the current shift is the WIDTH-th since the last clear/load.
module spi_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] data_next_o,
    output logic             ser_o,
    output logic             last_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] data_q;
    logic [CntW-1:0]  cnt_q;

    if (MSB_FIRST) begin : g_msb
        assign data_next_o = {data_q[WIDTH-2:0], ser_i};
        assign ser_o       = data_q[WIDTH-1];
    end else begin : g_lsb
        assign data_next_o = {ser_i, data_q[WIDTH-1:1]};
        assign ser_o       = data_q[0];
    end

    assign last_o = (cnt_q == CntW'(WIDTH - 1));

    // Data and counter update; load/clear restart the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= data_next_o;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: decodes {cmd, payload} frames for a single-port RAM and
// returns read data on MISO after a bounded tx_valid handshake.
module spi_slave_param #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned TX_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err,
    output logic              busy
);

    import spi_pkg::*;

    localparam int unsigned FRAME_W = DATA_W + 2;
    localparam int unsigned ToW     = $clog2(TX_TIMEOUT + 1);

    spi_state_e         state_q;
    logic               rd_seen_q;
    logic [FRAME_W-1:0] rx_data_q;
    logic               rx_valid_q;
    logic               frame_err_q;
    logic [ToW-1:0]     to_cnt_q;

    logic               rx_clr, rx_shift, rx_last;
    logic [FRAME_W-1:0] rx_frame;
    logic               tx_load, tx_shift, tx_last, tx_ser;
    logic               unused_rx_ser;
    logic [DATA_W-1:0]  unused_tx_next;

    // Shift-register strobes; nothing moves on an edge where ss_n is high.
    always_comb begin
        rx_clr   = (state_q == StChkCmd);
        rx_shift = !ss_n && (state_q inside {StWrite, StReadAdd, StReadData});
        tx_load  = !ss_n && (state_q == StTxWait) && tx_valid;
        tx_shift = !ss_n && (state_q == StTxShift);
    end

    spi_shift_reg #(
        .WIDTH     (FRAME_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx_sr (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (rx_clr),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (rx_shift),
        .ser_i       (mosi),
        .data_next_o (rx_frame),
        .ser_o       (unused_rx_ser),
        .last_o      (rx_last)
    );

    spi_shift_reg #(
        .WIDTH     (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx_sr (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (1'b0),
        .load_i      (tx_load),
        .load_data_i (tx_data),
        .shift_i     (tx_shift),
        .ser_i       (1'b0),
        .data_next_o (unused_tx_next),
        .ser_o       (tx_ser),
        .last_o      (tx_last)
    );

    // Frame FSM with registered pulses; ss_n high in any busy state returns to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_seen_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != StIdle && ss_n) begin
                state_q  <= StIdle;
                to_cnt_q <= '0;
                if (state_q != StWaitEnd) frame_err_q <= 1'b1;
                // An interrupted read-data transfer consumes the stored address.
                if (state_q inside {StTxWait, StTxShift}) rd_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!ss_n) state_q <= StChkCmd;
                    end
                    StChkCmd: begin
                        if (!mosi)          state_q <= StWrite;
                        else if (rd_seen_q) state_q <= StReadData;
                        else                state_q <= StReadAdd;
                    end
                    StWrite, StReadAdd, StReadData: begin
                        if (rx_last) begin
                            if (cmd_legal(state_q, rx_frame[FRAME_W-1 -: 2])) begin
                                rx_data_q  <= rx_frame;
                                rx_valid_q <= 1'b1;
                                if (state_q == StReadData) begin
                                    state_q <= StTxWait;
                                end else begin
                                    if (state_q == StReadAdd) rd_seen_q <= 1'b1;
                                    state_q <= StWaitEnd;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= StWaitEnd;
                            end
                        end
                    end
                    StTxWait: begin
                        if (tx_valid) begin
                            rd_seen_q <= 1'b0;
                            to_cnt_q  <= '0;
                            state_q   <= StTxShift;
                        end else if (to_cnt_q == ToW'(TX_TIMEOUT - 1)) begin
                            frame_err_q <= 1'b1;
                            rd_seen_q   <= 1'b0;
                            to_cnt_q    <= '0;
                            state_q     <= StWaitEnd;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    StTxShift: begin
                        if (tx_last) state_q <= StWaitEnd;
                    end
                    StWaitEnd: begin
                        state_q <= StWaitEnd;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign miso      = (state_q == StTxShift) & tx_ser;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised bench for spi_slave_param: an 8-bit MSB-first instance (a) and a
// 16-bit LSB-first instance (b). Stimulus tasks post per-cycle expectations
// derived from the frame being sent; one process compares every cycle.
module tb_spi_slave_param;

    localparam int TO   = 16;
    localparam int MAXC = 9000;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        ss_n_a   = 1'b1;
    logic        ss_n_b   = 1'b1;
    logic        mosi     = 1'b0;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data  = '0;

    logic        miso_a, rx_valid_a, frame_err_a, busy_a;
    logic [9:0]  rx_data_a;
    logic        miso_b, rx_valid_b, frame_err_b, busy_b;
    logic [17:0] rx_data_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected outputs per DUT per cycle (cycle n = after the n-th rising edge).
    bit          exp_rxv  [2][MAXC];
    bit          exp_err  [2][MAXC];
    bit          exp_miso [2][MAXC];
    bit          exp_txon [2][MAXC];
    bit          upd      [2][MAXC];
    logic [17:0] updv     [2][MAXC];
    logic [17:0] exp_rxd  [2];
    logic [15:0] hist     [2];
    bit          rd_seen  [2];
    bit          rst_s;
    bit          ss_s     [2];

    spi_slave_param #(
        .DATA_W     (8),
        .MSB_FIRST  (1'b1),
        .TX_TIMEOUT (TO)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .ss_n      (ss_n_a),
        .mosi      (mosi),
        .miso      (miso_a),
        .rx_data   (rx_data_a),
        .rx_valid  (rx_valid_a),
        .tx_data   (tx_data[7:0]),
        .tx_valid  (tx_valid),
        .frame_err (frame_err_a),
        .busy      (busy_a)
    );

    spi_slave_param #(
        .DATA_W     (16),
        .MSB_FIRST  (1'b0),
        .TX_TIMEOUT (TO)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .ss_n      (ss_n_b),
        .mosi      (mosi),
        .miso      (miso_b),
        .rx_data   (rx_data_b),
        .rx_valid  (rx_valid_b),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .frame_err (frame_err_b),
        .busy      (busy_b)
    );

    initial forever #5 clk = ~clk;

    function automatic int fw(input int d);
        return (d == 0) ? 10 : 18;
    endfunction

    function automatic int dw(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    // i-th frame bit on the wire.
    function automatic bit fbit(input int d, input logic [17:0] v, input int i);
        return (d == 0) ? v[9-i] : v[i];
    endfunction

    // k-th read-data bit on the wire.
    function automatic bit tbit(input int d, input logic [15:0] v, input int k);
        return (d == 0) ? v[7-k] : v[k];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic mi, input logic rv, input logic fe,
                             input logic bz, input logic [17:0] rd);
        if (upd[d][cyc]) exp_rxd[d] = updv[d][cyc];
        if (exp_txon[d][cyc]) hist[d] = {hist[d][14:0], mi};
        check($sformatf("rx_valid[%0d]", d), 32'(rv), 32'(exp_rxv[d][cyc]));
        check($sformatf("frame_err[%0d]", d), 32'(fe), 32'(exp_err[d][cyc]));
        check($sformatf("miso[%0d]", d), 32'(mi), 32'(exp_miso[d][cyc]));
        check($sformatf("busy[%0d]", d), 32'(bz), 32'(!rst_s && !ss_s[d]));
        check($sformatf("rx_data[%0d]", d), 32'(rd), 32'(exp_rxd[d]));
    endtask

    // Edge counter and input sampling at the active edge.
    initial forever begin
        @(posedge clk);
        cyc      = cyc + 1;
        rst_s    = rst;
        ss_s[0]  = ss_n_a;
        ss_s[1]  = ss_n_b;
    end

    // Per-cycle comparison, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cyc > 0 && cyc < MAXC) begin
            check_dut(0, miso_a, rx_valid_a, frame_err_a, busy_a, {8'h00, rx_data_a});
            check_dut(1, miso_b, rx_valid_b, frame_err_b, busy_b, rx_data_b);
        end
    end

    // Apply ss_n/mosi for one rising edge; on return cyc names that edge.
    task automatic drive(input int d, input bit ss, input bit m);
        if (d == 0) ss_n_a = ss;
        else        ss_n_b = ss;
        mosi = m;
        @(posedge clk);
        #1;
        if (cyc > MAXC - 100) begin
            errors++;
            $display("FAIL watchdog cyc=%0d got=overrun expected=limit %0d", cyc, MAXC - 100);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1);
        end
    endtask

    task automatic end_frame(input int d, input bit hold);
        if (hold) begin
            repeat ($urandom_range(0, 3)) begin
                tx_valid = 1'($urandom);
                drive(d, 1'b0, 1'($urandom));
            end
        end
        tx_valid = 1'b0;
        repeat (2) drive(d, 1'b1, 1'($urandom));
    endtask

    // ab: 0 = abort at command bit, 1..n = abort in place of frame bit ab-1, else none.
    // dly: tx_valid-low cycles in the wait (>= TO means timeout).
    // txab: 0 = abort in the wait, 1..w = abort at that shift edge, else none.
    task automatic run_frame(input int d, input bit cmdb, input logic [17:0] fv, input int ab,
                             input int dly, input logic [15:0] txv, input int txab,
                             input bit txrst);
        int n, w, c;
        logic [1:0] cmd;
        bit legal;
        n = fw(d);
        w = dw(d);
        drive(d, 1'b0, 1'($urandom));
        if (ab == 0) begin
            drive(d, 1'b1, 1'($urandom));
            exp_err[d][cyc] = 1'b1;
            end_frame(d, 1'b0);
            return;
        end
        drive(d, 1'b0, cmdb);
        for (int i = 0; i < n; i++) begin
            tx_valid = 1'($urandom);
            if (ab == i + 1) begin
                drive(d, 1'b1, 1'($urandom));
                exp_err[d][cyc] = 1'b1;
                end_frame(d, 1'b0);
                return;
            end
            drive(d, 1'b0, fbit(d, fv, i));
        end
        tx_valid = 1'b0;
        cmd = (d == 0) ? fv[9:8] : fv[17:16];
        if (!cmdb)           legal = (cmd[1] == 1'b0);
        else if (rd_seen[d]) legal = (cmd == 2'b11);
        else                 legal = (cmd == 2'b10);
        if (!legal) begin
            exp_err[d][cyc] = 1'b1;
        end else begin
            exp_rxv[d][cyc] = 1'b1;
            upd[d][cyc]     = 1'b1;
            updv[d][cyc]    = fv;
            if (cmdb && !rd_seen[d]) begin
                rd_seen[d] = 1'b1;
            end else if (cmdb) begin
                rd_seen[d] = 1'b0;
                if (dly >= TO) begin
                    repeat (TO) drive(d, 1'b0, 1'($urandom));
                    exp_err[d][cyc] = 1'b1;
                end else begin
                    repeat (dly) drive(d, 1'b0, 1'($urandom));
                    if (txab == 0) begin
                        drive(d, 1'b1, 1'($urandom));
                        exp_err[d][cyc] = 1'b1;
                        end_frame(d, 1'b0);
                        return;
                    end
                    tx_data  = txv;
                    tx_valid = 1'b1;
                    drive(d, 1'b0, 1'($urandom));
                    tx_valid = 1'b0;
                    tx_data  = 16'($urandom);
                    c = cyc;
                    for (int j = 1; j <= w; j++) begin
                        exp_miso[d][c+j-1] = tbit(d, txv, j - 1);
                        exp_txon[d][c+j-1] = 1'b1;
                        if (j == txab) begin
                            if (txrst) begin
                                rst = 1'b1;
                                drive(d, 1'b1, 1'($urandom));
                                rst = 1'b0;
                                for (int k = 0; k < 2; k++) begin
                                    upd[k][cyc]  = 1'b1;
                                    updv[k][cyc] = '0;
                                    rd_seen[k]   = 1'b0;
                                end
                                check("rst miso", 32'(d ? miso_b : miso_a), 32'd0);
                                check("rst busy", 32'(d ? busy_b : busy_a), 32'd0);
                            end else begin
                                drive(d, 1'b1, 1'($urandom));
                                exp_err[d][cyc] = 1'b1;
                            end
                            end_frame(d, 1'b0);
                            return;
                        end
                        drive(d, 1'b0, 1'($urandom));
                    end
                end
            end
        end
        end_frame(d, 1'b1);
    endtask

    task automatic rand_frame(input int d);
        bit cmdb;
        logic [1:0] cmd;
        logic [17:0] fv;
        int ab, dly, txab;
        cmdb = 1'($urandom);
        if ($urandom_range(0, 4) != 0) cmd = cmdb ? (rd_seen[d] ? 2'b11 : 2'b10) : {1'b0, 1'($urandom)};
        else                           cmd = 2'($urandom);
        fv   = (d == 0) ? {8'h00, cmd, 8'($urandom)} : {cmd, 16'($urandom)};
        ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, fw(d))) : 99;
        dly  = $urandom_range(0, 20);
        txab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, dw(d))) : -1;
        run_frame(d, cmdb, fv, ab, dly, 16'($urandom), txab, 1'b0);
    endtask

    initial begin
        exp_rxd[0] = '0;
        exp_rxd[1] = '0;
        hist[0]    = '0;
        hist[1]    = '0;
        repeat (3) drive(0, 1'b1, 1'b0);
        rst = 1'b0;
        check("reset rx_data_a", 32'(rx_data_a), 32'd0);
        check("reset busy_a", 32'(busy_a), 32'd0);
        drive(0, 1'b1, 1'b0);

        run_frame(0, 1'b0, 18'h004, 99, 0, 16'h0, -1, 1'b0);
        check("write addr rx_data", 32'(rx_data_a), 32'h004);
        run_frame(0, 1'b0, 18'h10F, 99, 0, 16'h0, -1, 1'b0);
        check("write data rx_data", 32'(rx_data_a), 32'h10F);
        run_frame(0, 1'b1, 18'h204, 99, 0, 16'h0, -1, 1'b0);
        check("read addr rx_data", 32'(rx_data_a), 32'h204);
        hist[0] = '0;
        run_frame(0, 1'b1, 18'h300, 99, 3, 16'h00AA, -1, 1'b0);
        check("read data rx_data", 32'(rx_data_a), 32'h300);
        check("read data miso bits", 32'(hist[0][7:0]), 32'hAA);
        run_frame(0, 1'b0, 18'h0F0, 6, 0, 16'h0, -1, 1'b0);
        check("abort keeps rx_data", 32'(rx_data_a), 32'h300);
        run_frame(0, 1'b0, 18'h0A5, 99, 0, 16'h0, -1, 1'b0);
        check("write after abort", 32'(rx_data_a), 32'h0A5);
        run_frame(0, 1'b1, 18'h3A7, 99, 0, 16'h0, -1, 1'b0);
        check("mismatch keeps rx_data", 32'(rx_data_a), 32'h0A5);
        run_frame(0, 1'b1, 18'h211, 99, 0, 16'h0, -1, 1'b0);
        run_frame(0, 1'b1, 18'h3FF, 99, TO, 16'h0, -1, 1'b0);
        check("timeout frame rx_data", 32'(rx_data_a), 32'h3FF);
        repeat (40) rand_frame(0);

        run_frame(1, 1'b0, 18'h01234, 99, 0, 16'h0, -1, 1'b0);
        check("lsb write rx_data", 32'(rx_data_b), 32'h01234);
        run_frame(1, 1'b1, 18'h20055, 99, 0, 16'h0, -1, 1'b0);
        check("lsb read addr rx_data", 32'(rx_data_b), 32'h20055);
        hist[1] = '0;
        run_frame(1, 1'b1, 18'h30000, 99, 1, 16'hA5C3, 5, 1'b1);
        check("reset clears rx_data_b", 32'(rx_data_b), 32'd0);
        check("reset clears rx_data_a", 32'(rx_data_a), 32'd0);
        check("lsb miso bits before reset", 32'(hist[1][4:0]), 32'h18);
        repeat (40) rand_frame(1);

        drive(1, 1'b1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
